// File: rtl/outr_serial_tx_if.sv
// Handshake bundle between the CPU output register and the serial output device.
interface outr_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] data;
  logic              ien;
  logic              clr_ovr;
  logic              fgo;
  logic              tx;
  logic              ovr;
  logic              irq;

  modport master (
    output load, data, ien, clr_ovr,
    input  fgo, tx, ovr, irq
  );

  modport slave (
    input  load, data, ien, clr_ovr,
    output fgo, tx, ovr, irq
  );
endinterface

// File: rtl/outr_serial_tx.sv
// Output register serializer: frames a parallel-loaded character as start bit,
// DATA_W data bits LSB first, stop bit; FGO reports readiness, irq = ien & FGO.
module outr_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             asyncclear_n,
  outr_serial_tx_if.slave  bus
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                tx_q, tx_d;
  logic                fgo_q, fgo_d;
  logic                ovr_q, ovr_d;
  logic                baud_end;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    fgo_d     = fgo_q;
    ovr_d     = ovr_q;
    baud_end  = (baud_q == BAUD_LAST);

    // An overrunning load beats a simultaneous clear.
    if (bus.clr_ovr)           ovr_d = 1'b0;
    if (bus.load && !fgo_q)    ovr_d = 1'b1;

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d = bus.data;
          fgo_d   = 1'b0;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = shift_d[0];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          fgo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      fgo_q     <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      fgo_q     <= fgo_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.tx  = tx_q;
  assign bus.fgo = fgo_q;
  assign bus.ovr = ovr_q;
  assign bus.irq = bus.ien & fgo_q;
endmodule
